// File: rtl/midi_pkg.sv
// Shared MIDI status constants, parser state encoding and the parsed note event.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } parse_state_t;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [6:0] vel;
    } midi_evt_t;

endpackage

// File: rtl/midi_msg_parser.sv
// Byte-level Note On/Off parser with running status for one MIDI channel;
// emits a registered one-cycle event after the velocity byte.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       evt_valid,
    output midi_evt_t  evt
);

    parse_state_t state_reg, state_next;
    logic         rs_on_reg, rs_on_next;
    logic [6:0]   note_reg, note_next;
    logic         evt_valid_reg, evt_valid_next;
    midi_evt_t    evt_reg, evt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rs_on_reg     <= 1'b0;
            note_reg      <= '0;
            evt_valid_reg <= 1'b0;
            evt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            rs_on_reg     <= rs_on_next;
            note_reg      <= note_next;
            evt_valid_reg <= evt_valid_next;
            evt_reg       <= evt_next;
        end
    end

    // Running status lives in state != IDLE plus the on/off flag.
    always_comb begin
        state_next     = state_reg;
        rs_on_next     = rs_on_reg;
        note_next      = note_reg;
        evt_valid_next = 1'b0;
        evt_next       = evt_reg;
        if (byte_valid) begin
            if (byte_data[7]) begin
                if (byte_data >= REALTIME_MIN) begin
                    state_next = state_reg;
                end else if (byte_data[3:0] == 4'(CHANNEL) &&
                             (byte_data[7:4] == NOTE_ON || byte_data[7:4] == NOTE_OFF)) begin
                    rs_on_next = (byte_data[7:4] == NOTE_ON);
                    state_next = WAIT_D1;
                end else begin
                    rs_on_next = 1'b0;
                    state_next = IDLE;
                end
            end else begin
                case (state_reg)
                    WAIT_D1: begin
                        note_next  = byte_data[6:0];
                        state_next = WAIT_D2;
                    end
                    WAIT_D2: begin
                        evt_valid_next = 1'b1;
                        evt_next.on    = rs_on_reg && (byte_data[6:0] != 7'd0);
                        evt_next.note  = note_reg;
                        evt_next.vel   = byte_data[6:0];
                        state_next     = WAIT_D1;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    assign evt_valid = evt_valid_reg;
    assign evt       = evt_reg;

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI note-to-voice allocator: retrigger, lowest free voice, else steal oldest
// (MIDI_VOICE_STEAL_EN) or drop and count the note-on.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic [7:0]              drop_cnt
);

    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic            evt_valid;
    midi_evt_t       evt;

    logic [NUM_VOICES-1:0] gate_reg;
    logic [NUM_VOICES-1:0] trig_reg;
    logic [6:0]            note_reg [NUM_VOICES];
    logic [6:0]            vel_reg  [NUM_VOICES];
    logic [AW-1:0]         age_reg  [NUM_VOICES];
    logic [7:0]            drop_reg;

    logic [NUM_VOICES-1:0] match;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] oldest;
    logic                  sel_valid;
    logic [AW-1:0]         sel_idx;

    midi_msg_parser #(
        .CHANNEL(CHANNEL)
    ) u_parser (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .evt_valid (evt_valid),
        .evt       (evt)
    );

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign match[gi]  = gate_reg[gi] && (note_reg[gi] == evt.note);
            assign free[gi]   = !gate_reg[gi];
            assign oldest[gi] = (age_reg[gi] == AW'(NUM_VOICES - 1));
            assign voice_note[7*gi +: 7] = note_reg[gi];
            assign voice_vel[7*gi +: 7]  = vel_reg[gi];
        end
    endgenerate

    // Descending scans so the lowest matching index wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (|match) begin
            sel_valid = 1'b1;
            for (int i = NUM_VOICES - 1; i >= 0; i--)
                if (match[i]) sel_idx = AW'(i);
        end else if (|free) begin
            sel_valid = 1'b1;
            for (int i = NUM_VOICES - 1; i >= 0; i--)
                if (free[i]) sel_idx = AW'(i);
        end
`ifdef MIDI_VOICE_STEAL_EN
        else begin
            sel_valid = 1'b1;
            for (int i = NUM_VOICES - 1; i >= 0; i--)
                if (oldest[i]) sel_idx = AW'(i);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_reg <= '0;
            trig_reg <= '0;
            drop_reg <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_reg[i] <= '0;
                vel_reg[i]  <= '0;
                age_reg[i]  <= AW'(i);
            end
        end else begin
            trig_reg <= '0;
            if (evt_valid) begin
                if (evt.on) begin
                    if (sel_valid) begin
                        // Voices younger than the chosen one age by one; chosen becomes newest.
                        for (int i = 0; i < NUM_VOICES; i++)
                            if (age_reg[i] < age_reg[sel_idx])
                                age_reg[i] <= age_reg[i] + AW'(1);
                        age_reg[sel_idx]  <= '0;
                        gate_reg[sel_idx] <= 1'b1;
                        trig_reg[sel_idx] <= 1'b1;
                        note_reg[sel_idx] <= evt.note;
                        vel_reg[sel_idx]  <= evt.vel;
                    end else if (drop_reg != 8'hFF) begin
                        drop_reg <= drop_reg + 8'd1;
                    end
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++)
                        if (match[i]) gate_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign voice_gate = gate_reg;
    assign voice_trig = trig_reg;
    assign drop_cnt   = drop_reg;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc with a queue-based reference model checked every cycle.
module tb_midi_voice_alloc;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic [NV-1:0]   voice_gate;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_vel;
    logic [NV-1:0]   voice_trig;
    logic [7:0]      drop_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int trig0_count = 0;

    midi_voice_alloc #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .voice_gate(voice_gate),
        .voice_note(voice_note),
        .voice_vel (voice_vel),
        .voice_trig(voice_trig),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: running-status byte plus collected data bytes; ages kept as a recency list.
    bit         m_ready = 0;
    bit         m_gate [NV];
    logic [6:0] m_note [NV];
    logic [6:0] m_vel  [NV];
    bit         m_trig [NV];
    int         m_drop;
    int         order[$];
    logic [7:0] rs;
    logic [6:0] dq[$];
    bit         pend_v, pend_on;
    logic [6:0] pend_note, pend_vel;

    task automatic model_apply();
        int idx = -1;
        if (pend_on) begin
            for (int i = NV - 1; i >= 0; i--) if (m_gate[i] && m_note[i] == pend_note) idx = i;
            if (idx < 0) for (int i = NV - 1; i >= 0; i--) if (!m_gate[i]) idx = i;
`ifdef MIDI_VOICE_STEAL_EN
            if (idx < 0) idx = order[$];
`endif
            if (idx < 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_gate[idx] = 1; m_note[idx] = pend_note; m_vel[idx] = pend_vel; m_trig[idx] = 1;
                for (int k = 0; k < order.size(); k++)
                    if (order[k] == idx) begin order.delete(k); break; end
                order.push_front(idx);
            end
        end else begin
            for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == pend_note) m_gate[i] = 0;
        end
    endtask

    task automatic model_parse(input logic [7:0] b);
        if (b >= 8'hF8) return;
        if (b[7]) begin
            rs = (b == 8'h80 || b == 8'h90) ? b : 8'h00;
            dq.delete();
        end else if (rs != 8'h00) begin
            dq.push_back(b[6:0]);
            if (dq.size() == 2) begin
                pend_v = 1; pend_note = dq[0]; pend_vel = dq[1];
                pend_on = (rs == 8'h90) && (dq[1] != 7'd0);
                dq.delete();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_ready = 1; m_drop = 0; rs = 8'h00; dq.delete(); pend_v = 0;
            order.delete();
            for (int i = 0; i < NV; i++) begin
                m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_trig[i] = 0;
                order.push_back(i);
            end
        end else begin
            for (int i = 0; i < NV; i++) m_trig[i] = 0;
            if (pend_v) model_apply();
            pend_v = 0;
            if (byte_valid) model_parse(byte_data);
        end
    end

    initial forever begin
        logic [NV-1:0]   eg, et;
        logic [7*NV-1:0] en, ev;
        @(negedge clk);
        trig0_count += int'(voice_trig[0]);
        if (m_ready) begin
            for (int i = 0; i < NV; i++) begin
                eg[i] = m_gate[i]; et[i] = m_trig[i];
                en[7*i +: 7] = m_note[i]; ev[7*i +: 7] = m_vel[i];
            end
            check("gate", 32'(voice_gate), 32'(eg));
            check("note", 32'(voice_note), 32'(en));
            check("vel",  32'(voice_vel),  32'(ev));
            check("trig", 32'(voice_trig), 32'(et));
            check("drop", 32'(drop_cnt),   32'(m_drop));
        end
    end

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1; byte_data = b;
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(3); rst_n = 1'b1;
    endtask

    task automatic expect_trig(input string name, input logic [NV-1:0] exp);
        @(posedge clk); #1;
        check(name, 32'(voice_trig), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        idle(1);
        do_reset();
        check("rst_gate", 32'(voice_gate), 32'h0);
        check("rst_note", 32'(voice_note), 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);

        // Running status across three note-ons.
        send(8'h90); send(8'h3C); send(8'h64); expect_trig("trig_v0", 4'b0001);
        send(8'h40); send(8'h50);              expect_trig("trig_v1", 4'b0010);
        send(8'h43); send(8'h7F);              expect_trig("trig_v2", 4'b0100);
        idle(2);
        check("rs_gate", 32'(voice_gate), 32'h7);
        check("rs_note", 32'(voice_note), 32'({7'h00, 7'h43, 7'h40, 7'h3C}));
        check("rs_vel",  32'(voice_vel),  32'({7'h00, 7'h7F, 7'h50, 7'h64}));

        // Both note-off forms; note is held after release.
        send(8'h80); send(8'h40); send(8'h00);
        send(8'h90); send(8'h3C); send(8'h00);
        idle(2);
        check("off_gate", 32'(voice_gate), 32'h4);
        check("off_note0", 32'(voice_note[6:0]), 32'h3C);

        // Wrong channel, other status with stale data, then realtime inside a message.
        send(8'h91); send(8'h3C); send(8'h64);
        send(8'hB0); send(8'h07); send(8'h7F);
        send(8'h3C); send(8'h64);
        idle(2);
        check("filt_gate", 32'(voice_gate), 32'h4);
        send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
        idle(2);
        check("rt_gate", 32'(voice_gate), 32'h5);

        // Pool exhaustion.
        do_reset();
        send(8'h90);
        for (int n = 0; n < 5; n++) begin send(8'h30 + 8'(n)); send(8'h01); end
        idle(2);
`ifdef MIDI_VOICE_STEAL_EN
        check("steal_note0", 32'(voice_note[6:0]), 32'h34);
        check("steal_drop", 32'(drop_cnt), 32'h0);
        send(8'h35); send(8'h01); idle(2);
        check("steal_note1", 32'(voice_note[13:7]), 32'h35);
`else
        check("drop_cnt1", 32'(drop_cnt), 32'h1);
        check("drop_gate", 32'(voice_gate), 32'hF);
        check("drop_note", 32'(voice_note), 32'({7'h33, 7'h32, 7'h31, 7'h30}));
        for (int n = 0; n < 260; n++) begin send(8'h36); send(8'h01); end
        idle(2);
        check("drop_sat", 32'(drop_cnt), 32'hFF);
`endif

        // Retrigger, then reset in the middle of a message.
        do_reset();
        trig0_count = 0;
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C); send(8'h20);
        idle(3);
        check("retrig_cnt", 32'(trig0_count), 32'd2);
        check("retrig_gate", 32'(voice_gate), 32'h1);
        check("retrig_vel0", 32'(voice_vel[6:0]), 32'h20);
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        idle(3);
        check("mid_rst_gate", 32'(voice_gate), 32'h0);
        check("mid_rst_note", 32'(voice_note), 32'h0);
        check("mid_rst_vel",  32'(voice_vel),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Consumes the byte stream from the MIDI UART receiver (one byte per valid pulse) and parses Note On/Note Off messages, including running status, on one configured channel.
- Schedules the synth's pool of NUM_VOICES oscillator voices: assigns each note to a voice, releases voices on note-off, and steals the oldest voice when the pool is full.
- Sits between the MIDI receiver and the voice/envelope datapath.

Parameters:
- NUM_VOICES, 4, number of voices in the pool (2..8).
- CHANNEL, 0, MIDI channel accepted (0..15); status low nibble must match.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- byte_valid  in  1  one-cycle strobe; byte_data is valid this cycle
- byte_data  in  8  received MIDI byte
- voice_gate  out  NUM_VOICES  per-voice gate; 1 = note held
- voice_note  out  7*NUM_VOICES  per-voice note number; voice i at [7i+6:7i]
- voice_vel  out  7*NUM_VOICES  per-voice velocity, same packing
- voice_trig  out  NUM_VOICES  one-cycle pulse when voice i starts or retriggers a note
- drop_cnt  out  8  count of note-ons discarded; saturates at 255

Behaviour:
- Reset: clk and rst_n are as already decided (reset rst_n, synchronous, active-low; clock clk). All outputs are 0. Voice ages are initialised to age[i]=i. Parser goes to IDLE. A message in flight at reset is discarded.
- Parser FSM states are IDLE, WAIT_D1 and WAIT_D2. Only cycles with byte_valid=1 are acted on.
  - Status byte 0x8C or 0x9C, where C = CHANNEL: latch as running status and go to WAIT_D1.
  - Status byte 0xF8..0xFF (realtime): ignored; state and running status unchanged.
  - Any other status byte: clear running status and go to IDLE.
  - Data byte (bit7=0) in IDLE: ignored.
  - Data byte in WAIT_D1: latch as note and go to WAIT_D2.
  - Data byte in WAIT_D2: latch as velocity, issue a one-cycle event, and return to WAIT_D1 (running status).
- Event classification:
  - 0x9C with velocity>0 is a note-on.
  - 0x8C with any velocity is a note-off.
  - 0x9C with velocity=0 is a note-off.
- Allocation latency: outputs update on the clock edge after the WAIT_D2 byte is registered (one cycle after the event). Bytes may arrive back-to-back; no backpressure is needed, since every event needs at least 2 bytes.
- Note-on, priority order:
  - (a) If a gated voice already holds the same note, retrigger it: update vel and pulse trig.
  - (b) Otherwise use the lowest-index voice with gate=0.
  - (c) Otherwise steal the voice with age=NUM_VOICES-1.
  - The chosen voice gets gate=1, note and vel loaded, and a trig pulse.
- Age update on every note-on: the chosen voice's age becomes 0. Each voice with age < the chosen voice's old age increments by 1. Ages always form a permutation of 0..NUM_VOICES-1.
- Note-off: every voice with gate=1 and a matching note gets gate=0. Note and vel are held so the release stage can use them. Ages are unchanged. A note-off with no match has no effect.
- voice_trig must never be asserted for more than 1 cycle per event.

Optional Feature:
- Macro: MIDI_VOICE_STEAL_EN.
- Defined: step (c) steals the oldest voice; drop_cnt stays 0.
- Undefined: when no voice is free and no match exists, the note-on is discarded. drop_cnt increments, and gates, notes and ages are unchanged.

Decomposition:
- Package midi_pkg holds:
  - status constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, REALTIME_MIN=8'hF8;
  - enum parse_state_t {IDLE, WAIT_D1, WAIT_D2};
  - struct midi_evt_t {on, note[6:0], vel[6:0]}.
- Sub-module midi_msg_parser: byte-level FSM that outputs evt_valid and midi_evt_t. midi_voice_alloc instantiates it and contains the allocation and age logic.

Test Plan (CHANNEL=0, NUM_VOICES=4):
- Running status: bytes 90 3C 64, then 40 50, then 43 7F -> voices 0, 1 and 2 hold notes 3C, 40, 43 with vels 64, 50, 7F. Gates=0111; 3 trig pulses, each 1 cycle after the last byte of its message.
- Note-off forms: after the above, send 80 40 00 and 90 3C 00 -> gates=0100; voice0 note stays 3C.
- Filtering: 91 3C 64 (channel 1), then B0 07 7F, then 3C 64 -> no gate change. F8 injected between 90 and 3C -> note-on still accepted.
- Steal (MIDI_VOICE_STEAL_EN): note-ons 30, 31, 32, 33, then 34 -> voice0 becomes note 34 with trig[0] pulsed; the next note-on 35 lands on voice1.
- No steal (macro undefined): same stimulus -> note 34 dropped, drop_cnt=1, gates=1111, notes unchanged.
- Retrigger and reset: 90 3C 64, then 90 3C 20 -> single voice0, vel=20, trig pulsed twice. Assert rst_n=0 after the 90 3C bytes of a further message -> all outputs 0; the following byte 64 is ignored.
